// File: rtl/mux_pkg.sv
// Shared constants for the arb_mux selector: the operating mode encoding.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating-priority request picker: the first set request after ptr, wrapping mod N.
module rr_pick #(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);

   logic [SEL_W-1:0] idx_s;

   // Walk the ring from farthest to nearest so the nearest requester wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx_s     = '0;
      for (int k = N; k >= 1; k--) begin
         idx_s     = SEL_W'((32'(ptr) + 32'(k)) % 32'(N));
         gnt_valid = gnt_valid | req[idx_s];
         gnt_idx   = req[idx_s] ? idx_s : gnt_idx;
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-input registered selector with valid/ready on every channel; direct-select or
// round-robin grant feeding a one-entry output register.
module arb_mux
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(N - 1);
   localparam logic [N-1:0]     ONE_HOT0  = N'(1);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             rr_gnt_valid_s;
   logic [SEL_W-1:0] rr_gnt_idx_s;
   logic             sel_ok_s;
   logic             grant_valid_s;
   logic [SEL_W-1:0] grant_idx_s;
   logic             load_s;
   logic             xfer_s;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .gnt_valid (rr_gnt_valid_s),
      .gnt_idx   (rr_gnt_idx_s)
   );

   // Grant source: sel index (guarded against out-of-range values) or the RR picker.
   always_comb begin
      sel_ok_s      = (32'(sel) < 32'(N));
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
      case (mode)
         MODE_SEL: begin
            if (sel_ok_s) begin
               grant_valid_s = in_valid[sel];
               grant_idx_s   = sel;
            end else begin
               grant_valid_s = 1'b0;
               grant_idx_s   = '0;
            end
         end
         MODE_RR: begin
            grant_valid_s = rr_gnt_valid_s;
            grant_idx_s   = rr_gnt_idx_s;
         end
         default: begin
            grant_valid_s = 1'b0;
            grant_idx_s   = '0;
         end
      endcase
   end

   // Handshake decode and next state; ready is held low while reset is asserted so no beat is lost.
   always_comb begin
      load_s      = rst_n && (!out_valid_q || out_ready);
      xfer_s      = load_s && grant_valid_s;
      in_ready    = '0;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer_s) begin
         in_ready    = ONE_HOT0 << grant_idx_s;
         out_data_d  = in_data[32'(grant_idx_s) * WIDTH +: WIDTH];
         out_src_d   = grant_idx_s;
         out_valid_d = 1'b1;
         if (mode == MODE_RR) begin
            rr_ptr_d = grant_idx_s;
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end else if (load_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= PTR_RESET;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a behavioural model of the selector.
module tb_arb_mux;
   import mux_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic [1:0]     sel;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_valid;
   logic           out_ready;

   logic           b_mode;
   logic [1:0]     b_sel;
   logic [3*W-1:0] b_data;
   logic [2:0]     b_valid;
   logic [2:0]     b_ready;
   logic [W-1:0]   b_out_data;
   logic [1:0]     b_out_src;
   logic           b_out_valid;
   logic           b_out_ready;

   int total = 0;
   int bad   = 0;
   logic check_en = 1'b0;
   logic [N-1:0] rdy_seen = '0;
   logic [N-1:0] acc;

   arb_mux #(.WIDTH(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   arb_mux #(.WIDTH(W), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
      .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
      .out_ready(b_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: one register slot, a pointer to the last RR winner.
   logic         m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   int           m_src   = 0;
   int           m_ptr   = N - 1;
   int           m_g;

   function automatic int grant_of(logic md, logic [1:0] s, logic [N-1:0] v, int ptr);
      if (md == MODE_SEL) return v[s] ? int'(s) : -1;
      for (int k = 1; k <= N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   always_comb m_g = grant_of(mode, sel, in_valid, m_ptr);

   function automatic logic [N-1:0] exp_ready();
      if (!rst_n) return '0;
      if (m_valid && !out_ready) return '0;
      if (m_g < 0) return '0;
      return N'(1 << m_g);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_src   <= 0;
         m_ptr   <= N - 1;
      end else if (!m_valid || out_ready) begin
         if (m_g >= 0) begin
            m_valid <= 1'b1;
            m_data  <= in_data[m_g*W +: W];
            m_src   <= m_g;
            if (mode == MODE_RR) m_ptr <= m_g;
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: model comparison at the falling edge, then step past the rising edge.
   task automatic cycle();
      @(negedge clk);
      if (check_en && rst_n) begin
         chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
         chk("cyc_out_data",  64'(out_data),  64'(m_data));
         chk("cyc_out_src",   64'(out_src),   64'(m_src));
         chk("cyc_in_ready",  64'(in_ready),  64'(exp_ready()));
      end
      rdy_seen = in_ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; mode = MODE_SEL; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
      b_mode = MODE_SEL; b_sel = 2'd0; b_data = '0; b_valid = '0; b_out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_src",   64'(out_src),   64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_b_valid",   64'(b_out_valid), 64'd0);
      @(posedge clk); @(posedge clk); #1;

      rst_n = 1'b1; mode = MODE_RR; in_valid = 4'hF; out_ready = 1'b1; check_en = 1'b1;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000_0000 + 32'(i);
      #3 chk("first_rr_ready", 64'(in_ready), 64'(4'b0001));
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("rr_seq_src",   64'(out_src),   64'(k % N));
         chk("rr_seq_valid", 64'(out_valid), 64'd1);
      end

      mode = MODE_SEL; sel = 2'd2; in_data[2*W +: W] = 32'hDEAD_BEEF;
      #3 chk("sel_ready", 64'(in_ready), 64'(4'b0100));
      cycle();
      chk("sel_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
      chk("sel_src",  64'(out_src),  64'd2);

      mode = MODE_RR; in_valid = 4'b1010;
      cycle();
      chk("rr1010_src", 64'(out_src), 64'd1);
      out_ready = 1'b0;
      #3 chk("stall_ready", 64'(in_ready), 64'd0);
      cycle();
      chk("stall_src",   64'(out_src),   64'd1);
      chk("stall_valid", 64'(out_valid), 64'd1);
      cycle();
      chk("stall_src2",  64'(out_src),   64'd1);
      out_ready = 1'b1;
      #3 chk("unstall_ready", 64'(in_ready), 64'(4'b1000));
      cycle();
      chk("unstall_src3", 64'(out_src), 64'd3);
      cycle();
      chk("unstall_src1", 64'(out_src), 64'd1);

      b_valid = 3'b111; b_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) b_data[i*W +: W] = 32'hA0A0_0000 + 32'(i);
      cycle();
      chk("n3_sel0_valid", 64'(b_out_valid), 64'd1);
      chk("n3_sel0_data",  64'(b_out_data),  64'hA0A0_0000);
      b_sel = 2'd3;
      #3 chk("n3_sel3_ready", 64'(b_ready), 64'd0);
      cycle();
      chk("n3_sel3_valid", 64'(b_out_valid), 64'd0);
      chk("n3_sel3_data",  64'(b_out_data),  64'hA0A0_0000);
      chk("n3_sel3_src",   64'(b_out_src),   64'd0);
      b_sel = 2'd2;
      #3 chk("n3_sel2_ready", 64'(b_ready), 64'(3'b100));
      cycle();
      chk("n3_sel2_src", 64'(b_out_src), 64'd2);

      in_valid = 4'hF;
      cycle();
      out_ready = 1'b0;
      cycle();
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_data",  64'(out_data),  64'd0);
      chk("midrst_src",   64'(out_src),   64'd0);
      chk("midrst_ready", 64'(in_ready),  64'd0);
      cycle();
      rst_n = 1'b1; out_ready = 1'b1;
      #3 chk("postrst_ready", 64'(in_ready), 64'(4'b0001));
      cycle();
      chk("postrst_src", 64'(out_src), 64'd0);

      for (int c = 0; c < 1500; c++) begin
         cycle();
         acc = in_valid & rdy_seen;
         for (int i = 0; i < N; i++) begin
            if (!in_valid[i] || acc[i]) begin
               in_valid[i]       = ($urandom_range(0, 9) < 6);
               in_data[i*W +: W] = $urandom;
            end
         end
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel       = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
